writeback_arbiter: RTL and testbench

Parametrised multi-source writeback stage for the Trireme cores. It accepts register-file write results from `NUM_SRC` independent producers (e.g. ALU, load unit, long-latency mul/div) through valid/ready handshakes and buffers each source in its own small queue. It drains the queues round-robin onto a single registered register-file write port. It replaces the fixed two-way ALU/memory select for pipelines whose functional units complete out of step.

---
 rtl/writeback_defs.sv | 11 +
 rtl/wb_queue.sv | 62 ++++++
 rtl/writeback_arbiter.sv | 148 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_defs.sv
// Shared definitions for the Trireme writeback stage: x0 address and queue pointer width.
`ifndef WB_PTR_W
`define WB_PTR_W(depth) ($clog2(depth) + 1)
`endif

package writeback_defs;

  // Architectural zero register; writes to it are dropped at the input.
  localparam int unsigned X0_ADDR = 0;

endpackage

// File: rtl/wb_queue.sv
// Single-clock FIFO with wrap-bit pointers; one extra pointer bit separates full from empty.
// Optional build macro TRIREME_WB_SCAN_EN exposes the occupancy count.
module wb_queue #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
`ifdef TRIREME_WB_SCAN_EN
  ,
  output logic [`WB_PTR_W(DEPTH)-1:0] count
`endif
);

  localparam int unsigned PTR_W = `WB_PTR_W(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags from pointer comparison only.
  always_comb begin
    full    = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
              (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    empty   = (wptr_q == rptr_q);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wptr_d  = do_push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;
    rdata   = mem_q[rptr_q[IDX_W-1:0]];
  end

`ifdef TRIREME_WB_SCAN_EN
  assign count = wptr_q - rptr_q;
`endif

  // Pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Multi-source writeback stage: per-source queues drained round-robin onto one
// registered register-file write port. Optional build macro TRIREME_WB_SCAN_EN
// adds the scan input, a cycle counter and a per-cycle state dump.
module writeback_arbiter
  import writeback_defs::*;
#(
  parameter int          CORE           = 0,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned QUEUE_DEPTH    = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_reg,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]     src_data,
  output logic                              write,
  output logic [REG_ADDR_WIDTH-1:0]         write_reg,
  output logic [DATA_WIDTH-1:0]             write_data,
  output logic [NUM_SRC-1:0]                pending
`ifdef TRIREME_WB_SCAN_EN
  ,
  input  logic                              scan
`endif
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + REG_ADDR_WIDTH;
  localparam int unsigned SRC_W   = $clog2(NUM_SRC);
  localparam int unsigned PTR_W   = `WB_PTR_W(QUEUE_DEPTH);

  if (NUM_SRC < 2 || NUM_SRC > 8 || QUEUE_DEPTH < 2 ||
      (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || CORE < 0) begin : g_bad_cfg
    $error("writeback_arbiter: unsupported parameter set");
  end

  logic [NUM_SRC-1:0] q_full;
  logic [NUM_SRC-1:0] q_empty;
  logic [NUM_SRC-1:0] q_push;
  logic [NUM_SRC-1:0] q_pop;
  logic [ENTRY_W-1:0] q_head [NUM_SRC];
`ifdef TRIREME_WB_SCAN_EN
  logic [PTR_W-1:0]   q_count [NUM_SRC];
`endif

  logic [SRC_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      arb_found;
  logic [SRC_W-1:0]          arb_win;
  logic [SRC_W-1:0]          arb_idx;
  logic                      write_q, write_d;
  logic [REG_ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;

  // One queue per producer; x0 results are consumed but never enqueued.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign q_push[g] = src_valid[g] & ~q_full[g] &
                       (src_reg[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] !=
                        REG_ADDR_WIDTH'(X0_ADDR));

    wb_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH)
    ) u_queue (
      .clock (clock),
      .reset (reset),
      .push  (q_push[g]),
      .pop   (q_pop[g]),
      .wdata ({src_reg[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
               src_data[g*DATA_WIDTH +: DATA_WIDTH]}),
      .rdata (q_head[g]),
      .full  (q_full[g]),
      .empty (q_empty[g])
`ifdef TRIREME_WB_SCAN_EN
      ,
      .count (q_count[g])
`endif
    );
  end

  assign src_ready  = ~q_full;
  assign pending    = ~q_empty;
  assign write      = write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

  // Round-robin search from rr_ptr upward; winner's head is dequeued and registered.
  always_comb begin
    arb_found    = 1'b0;
    arb_win      = '0;
    arb_idx      = '0;
    q_pop        = '0;
    rr_ptr_d     = rr_ptr_q;
    write_d      = 1'b0;
    write_reg_d  = '0;
    write_data_d = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      arb_idx = SRC_W'((32'(rr_ptr_q) + off) % NUM_SRC);
      if (!arb_found && !q_empty[arb_idx]) begin
        arb_found = 1'b1;
        arb_win   = arb_idx;
      end
    end
    if (arb_found) begin
      q_pop                       = NUM_SRC'(1) << arb_win;
      rr_ptr_d                    = (arb_win == SRC_W'(NUM_SRC - 1)) ? '0
                                                                     : arb_win + SRC_W'(1);
      write_d                     = 1'b1;
      {write_reg_d, write_data_d} = q_head[arb_win];
    end
  end

  // Output port and arbitration pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      write_q      <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      write_q      <= write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

`ifdef TRIREME_WB_SCAN_EN
  logic [31:0] cycle_q;

  // Free-running cycle count for the scan dump.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_q + 32'd1;
  end

  // Per-cycle state dump while scan is held high.
  always_ff @(posedge clock) begin
    if (scan) begin
      $display("wb core=%0d cycle=%0d rr_ptr=%0d write=%0b write_reg=%0d write_data=%h",
               CORE, cycle_q, rr_ptr_q, write_q, write_reg_q, write_data_q);
      for (int i = 0; i < NUM_SRC; i++)
        $display("wb core=%0d queue=%0d occupancy=%0d", CORE, i, q_count[i]);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: vector table plus contention and reset sequences.
module tb_writeback_arbiter;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int RW = 5;

  logic           clock;
  logic           reset;
  logic [NS-1:0]  src_valid;
  logic [NS-1:0]  src_ready;
  logic [NS*RW-1:0] src_reg;
  logic [NS*DW-1:0] src_data;
  logic           write;
  logic [RW-1:0]  write_reg;
  logic [DW-1:0]  write_data;
  logic [NS-1:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_arbiter #(
    .CORE(0), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .NUM_SRC(NS), .QUEUE_DEPTH(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_reg    (src_reg),
    .src_data   (src_data),
    .write      (write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .pending    (pending)
`ifdef TRIREME_WB_SCAN_EN
    ,
    .scan       (1'b0)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [NS-1:0]    valid;
    logic [NS*RW-1:0] regs;
    logic [NS*DW-1:0] data;
    logic             exp_write;
    logic [RW-1:0]    exp_reg;
    logic [DW-1:0]    exp_data;
    logic [NS-1:0]    exp_ready;
    logic [NS-1:0]    exp_pend;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] v,
                              input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic ew, input logic [4:0] er, input logic [31:0] ed,
                              input logic [2:0] ep);
    vec_t t;
    t.valid     = v;
    t.regs      = {r2, r1, r0};
    t.data      = {d2, d1, d0};
    t.exp_write = ew;
    t.exp_reg   = er;
    t.exp_data  = ed;
    t.exp_ready = 3'b111;
    t.exp_pend  = ep;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    src_valid = '0;
    src_reg   = '0;
    src_data  = '0;
  endtask

  vec_t vecs [19];

  logic [31:0] sb [NS][$];
  int          seq [NS];
  int          src2_cyc [$];
  int          acc2;
  logic        saw_full2;
  logic        done;
  int          src;

  initial begin
    // Expected values: vector k's inputs are sampled at an edge, outputs checked just after it.
    vecs[0]  = mk(3'b111, 1, 2, 3, 10, 20, 30, 0, 0, 0,  3'b111);
    vecs[1]  = mk(3'b000, 0, 0, 0,  0,  0,  0, 1, 1, 10, 3'b110);
    vecs[2]  = mk(3'b000, 0, 0, 0,  0,  0,  0, 1, 2, 20, 3'b100);
    vecs[3]  = mk(3'b000, 0, 0, 0,  0,  0,  0, 1, 3, 30, 3'b000);
    vecs[4]  = mk(3'b000, 0, 0, 0,  0,  0,  0, 0, 0, 0,  3'b000);
    vecs[5]  = mk(3'b001, 3, 0, 0,  5,  0,  0, 0, 0, 0,  3'b001);
    vecs[6]  = mk(3'b000, 0, 0, 0,  0,  0,  0, 1, 3, 5,  3'b000);
    vecs[7]  = mk(3'b000, 0, 0, 0,  0,  0,  0, 0, 0, 0,  3'b000);
    vecs[8]  = mk(3'b111, 4, 5, 6, 40, 50, 60, 0, 0, 0,  3'b111);
    vecs[9]  = mk(3'b000, 0, 0, 0,  0,  0,  0, 1, 5, 50, 3'b101);
    vecs[10] = mk(3'b000, 0, 0, 0,  0,  0,  0, 1, 6, 60, 3'b001);
    vecs[11] = mk(3'b000, 0, 0, 0,  0,  0,  0, 1, 4, 40, 3'b000);
    vecs[12] = mk(3'b000, 0, 0, 0,  0,  0,  0, 0, 0, 0,  3'b000);
    vecs[13] = mk(3'b010, 0, 0, 0,  0, 32'hDEAD, 0, 0, 0, 0, 3'b000);
    vecs[14] = mk(3'b000, 0, 0, 0,  0,  0,  0, 0, 0, 0,  3'b000);
    vecs[15] = mk(3'b100, 0, 0, 7,  0,  0, 70, 0, 0, 0,  3'b100);
    vecs[16] = mk(3'b100, 0, 0, 8,  0,  0, 80, 1, 7, 70, 3'b100);
    vecs[17] = mk(3'b000, 0, 0, 0,  0,  0,  0, 1, 8, 80, 3'b000);
    vecs[18] = mk(3'b000, 0, 0, 0,  0,  0,  0, 0, 0, 0,  3'b000);

    // Reset held with every source valid: nothing is accepted or written.
    reset     = 1'b0;
    src_valid = '1;
    src_reg   = {5'd3, 5'd2, 5'd1};
    src_data  = {32'd3, 32'd2, 32'd1};
    repeat (3) tick();
    chk("rst_write", write, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_ready", src_ready, 3'b111);
    chk("rst_pending", pending, 0);
    idle_inputs();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) begin
      tick();
      chk("post_rst_no_write", write, 0);
    end

    // Table-driven vectors.
    for (int i = 0; i < 19; i++) begin
      src_valid = vecs[i].valid;
      src_reg   = vecs[i].regs;
      src_data  = vecs[i].data;
      if (i == 13) chk("x0_ready_before_edge", src_ready[1], 1);
      tick();
      chk($sformatf("v%0d_write", i), write, vecs[i].exp_write);
      chk($sformatf("v%0d_reg", i), write_reg, vecs[i].exp_reg);
      chk($sformatf("v%0d_data", i), write_data, vecs[i].exp_data);
      chk($sformatf("v%0d_ready", i), src_ready, vecs[i].exp_ready);
      chk($sformatf("v%0d_pending", i), pending, vecs[i].exp_pend);
    end
    idle_inputs();

    // Contention: sources 0/1 stream, source 2 offers four entries; scoreboard per source.
    for (int s = 0; s < NS; s++) seq[s] = 0;
    acc2      = 0;
    saw_full2 = 1'b0;
    done      = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      src_valid[0] = (cyc < 20);
      src_valid[1] = (cyc < 20);
      src_valid[2] = (acc2 < 4);
      for (int s = 0; s < NS; s++) begin
        src_reg[s*RW +: RW]  = RW'(s + 1);
        src_data[s*DW +: DW] = {16'(s), 16'(seq[s])};
      end
      @(negedge clock);
      if (!src_ready[2]) saw_full2 = 1'b1;
      for (int s = 0; s < NS; s++) begin
        if (src_valid[s] && src_ready[s]) begin
          sb[s].push_back({16'(s), 16'(seq[s])});
          seq[s]++;
          if (s == 2) acc2++;
        end
      end
      tick();
      if (write) begin
        src = int'(write_data[31:16]);
        if (src >= NS) begin
          chk("stream_src_id", 64'(src), 0);
        end else begin
          chk("stream_reg", write_reg, 64'(src + 1));
          chk("stream_sb_nonempty", 64'(sb[src].size() != 0), 1);
          if (sb[src].size() != 0) chk("stream_data", write_data, sb[src].pop_front());
          if (src == 2) src2_cyc.push_back(cyc);
        end
      end
      done = (cyc >= 20) && (acc2 >= 4) && !write &&
             (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0);
    end
    idle_inputs();
    chk("stream_drained", done, 1);
    chk("src2_ready_dropped", saw_full2, 1);
    chk("src2_writes", 64'(src2_cyc.size()), 4);
    for (int k = 1; k < src2_cyc.size(); k++)
      chk($sformatf("src2_gap%0d", k), 64'(src2_cyc[k] - src2_cyc[k-1]), 3);
    chk("stream_pending_idle", pending, 0);

    // Reset mid-operation: queued entries vanish and write drops before the next edge.
    src_valid = 3'b111;
    src_reg   = {5'd11, 5'd10, 5'd9};
    src_data  = {32'd111, 32'd110, 32'd109};
    tick();
    idle_inputs();
    tick();
    chk("mid_write_active", write, 1);
    chk("mid_pending_two", pending != 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_write", write, 0);
    chk("mid_rst_write_reg", write_reg, 0);
    chk("mid_rst_write_data", write_data, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_ready", src_ready, 3'b111);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) begin
      tick();
      chk("post_mid_rst_no_write", write, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
